// File: rtl/pong_pkg.sv
// Shared Pong types: BCD score struct, winning-score constants and miss FSM states.
package pong_pkg;

  typedef struct packed {
    logic       tens;
    logic [3:0] ones;
  } score_t;

  localparam score_t WIN_SCORE_11 = 5'h11;
  localparam score_t WIN_SCORE_15 = 5'h15;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    LOCK  = 2'd2
  } miss_state_t;

  // Packed {tens, ones} orders numerically because tens sits above a 0-9 ones digit.
  function automatic logic score_reached(input score_t s, input score_t target);
    return {s.tens, s.ones} >= {target.tens, target.ones};
  endfunction

endpackage

// File: rtl/score_cntl_if.sv
// Boundary-hit inputs, game controls and score/miss outputs of the scoring block.
interface score_cntl_if;
  logic       SRST;
  logic       ATTRACT;
  logic       HIT_LEFT;
  logic       HIT_RIGHT;
  logic       SCORE_15;
  logic       MISS_N;
  logic       STOP_G;
  logic       SCORE1_TENS;
  logic [3:0] SCORE1_ONES;
  logic       SCORE2_TENS;
  logic [3:0] SCORE2_ONES;

  modport master (
    output SRST, ATTRACT, HIT_LEFT, HIT_RIGHT, SCORE_15,
    input  MISS_N, STOP_G, SCORE1_TENS, SCORE1_ONES, SCORE2_TENS, SCORE2_ONES
  );

  modport slave (
    input  SRST, ATTRACT, HIT_LEFT, HIT_RIGHT, SCORE_15,
    output MISS_N, STOP_G, SCORE1_TENS, SCORE1_ONES, SCORE2_TENS, SCORE2_ONES
  );
endinterface

// File: rtl/bcd_score_counter.sv
// One player's BCD score: ones 0-9, tens 0-1; clr wins over inc, inh freezes it.
module bcd_score_counter
  import pong_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   clr,
  input  logic   inc,
  input  logic   inh,
  output score_t score
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      score <= '0;
    end else if (clr) begin
      score <= '0;
    end else if (inc && !inh) begin
      if (score.ones == 4'd9) begin
        score.tens <= 1'b1;
        score.ones <= 4'd0;
      end else begin
        score.ones <= score.ones + 4'd1;
      end
    end
  end

endmodule

// File: rtl/score_cntl.sv
// Pong scoring: boundary-hit edges -> MISS_N pulse, BCD scores and STOP_G game over.
module score_cntl
  import pong_pkg::*;
#(
  parameter int MISS_CYCLES = 14318
) (
  input  logic         CLK_DRV,
  input  logic         FPGA_RESET,
  score_cntl_if.slave  bus
);

  localparam int CNT_W = (MISS_CYCLES > 1) ? $clog2(MISS_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MISS_CYCLES - 1);

  miss_state_t      state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             hit_l_q, hit_r_q;
  logic             miss_l, miss_r;
  logic             start;
  logic             miss_n_q, stop_q;
  logic             inc1, inc2, inh;
  score_t           win, score1, score2;

  assign miss_l = bus.HIT_LEFT  & ~hit_l_q;
  assign miss_r = bus.HIT_RIGHT & ~hit_r_q;

  assign win = bus.SCORE_15 ? WIN_SCORE_15 : WIN_SCORE_11;
  assign inh = score_reached(score1, win) | score_reached(score2, win);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    start     = 1'b0;
    if (bus.SRST) begin
      state_nxt = LOCK;
    end else begin
      case (state)
        IDLE: begin
          if ((miss_l || miss_r) && !stop_q) begin
            state_nxt = PULSE;
            cnt_nxt   = CNT_LOAD;
            start     = 1'b1;
          end
        end
        PULSE: begin
          if (cnt == '0) state_nxt = LOCK;
          else           cnt_nxt   = cnt - CNT_W'(1);
        end
        LOCK: begin
          // Wait for the ball to leave both boundaries so a lingering hit cannot re-trigger.
          if (!bus.HIT_LEFT && !bus.HIT_RIGHT) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Left has priority when both edges land in the same cycle.
  assign inc2 = start & ~bus.ATTRACT & miss_l;
  assign inc1 = start & ~bus.ATTRACT & ~miss_l;

  always_ff @(posedge CLK_DRV or posedge FPGA_RESET) begin
    if (FPGA_RESET) begin
      state    <= IDLE;
      cnt      <= '0;
      hit_l_q  <= 1'b0;
      hit_r_q  <= 1'b0;
      miss_n_q <= 1'b1;
      stop_q   <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      hit_l_q  <= bus.HIT_LEFT;
      hit_r_q  <= bus.HIT_RIGHT;
      miss_n_q <= (state_nxt != PULSE);
      if (bus.SRST)  stop_q <= 1'b0;
      else if (inh)  stop_q <= 1'b1;
    end
  end

  bcd_score_counter u_score1 (
    .clk   (CLK_DRV),
    .rst   (FPGA_RESET),
    .clr   (bus.SRST),
    .inc   (inc1),
    .inh   (inh),
    .score (score1)
  );

  bcd_score_counter u_score2 (
    .clk   (CLK_DRV),
    .rst   (FPGA_RESET),
    .clr   (bus.SRST),
    .inc   (inc2),
    .inh   (inh),
    .score (score2)
  );

  assign bus.MISS_N      = miss_n_q;
  assign bus.STOP_G      = stop_q;
  assign bus.SCORE1_TENS = score1.tens;
  assign bus.SCORE1_ONES = score1.ones;
  assign bus.SCORE2_TENS = score2.tens;
  assign bus.SCORE2_ONES = score2.ones;

endmodule

// File: tb/tb_score_cntl.sv
// Directed bench for score_cntl with an 8-cycle miss pulse.
module tb_score_cntl;

  logic CLK_DRV;
  logic FPGA_RESET;
  int   total;
  int   bad;

  score_cntl_if sif ();

  score_cntl #(.MISS_CYCLES(8)) dut (
    .CLK_DRV    (CLK_DRV),
    .FPGA_RESET (FPGA_RESET),
    .bus        (sif.slave)
  );

  initial CLK_DRV = 1'b0;
  always #5 CLK_DRV = ~CLK_DRV;

  // Inputs are driven and outputs sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge CLK_DRV);
    #1;
  endtask

  function automatic logic [4:0] p1();
    return {sif.SCORE1_TENS, sif.SCORE1_ONES};
  endfunction

  function automatic logic [4:0] p2();
    return {sif.SCORE2_TENS, sif.SCORE2_ONES};
  endfunction

  task automatic do_srst();
    sif.SRST = 1'b1;
    tick();
    sif.SRST = 1'b0;
    tick();
  endtask

  // Hold the given hits for 'hold' cycles, counting MISS_N low cycles, then release.
  task automatic run_miss(input logic l, input logic r, input int hold,
                          output int lows, output int first);
    lows  = 0;
    first = 0;
    sif.HIT_LEFT  = l;
    sif.HIT_RIGHT = r;
    for (int i = 1; i <= hold; i++) begin
      tick();
      if (sif.MISS_N === 1'b0) begin
        lows++;
        if (first == 0) first = i;
      end
    end
    sif.HIT_LEFT  = 1'b0;
    sif.HIT_RIGHT = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    sif.SRST = 1'b0; sif.ATTRACT = 1'b0; sif.HIT_LEFT = 1'b0;
    sif.HIT_RIGHT = 1'b0; sif.SCORE_15 = 1'b0;
    FPGA_RESET = 1'b1;
    tick();
    tick();
    total++;
    if (sif.MISS_N !== 1'b1) begin bad++; $display("FAIL reset_miss_n got=%b exp=1", sif.MISS_N); end
    total++;
    if (sif.STOP_G !== 1'b0) begin bad++; $display("FAIL reset_stop_g got=%b exp=0", sif.STOP_G); end
    total++;
    if (p1() !== 5'h00 || p2() !== 5'h00) begin
      bad++; $display("FAIL reset_scores got=%h/%h exp=00/00", p1(), p2());
    end
    FPGA_RESET = 1'b0;
    tick();
  endtask

  task automatic test_right_miss();
    int lows, first;
    run_miss(1'b0, 1'b1, 100, lows, first);
    total++;
    if (lows !== 8) begin bad++; $display("FAIL right_pulse_len got=%0d exp=8", lows); end
    total++;
    if (first !== 1) begin bad++; $display("FAIL right_pulse_start got=%0d exp=1", first); end
    total++;
    if (p1() !== 5'h01 || p2() !== 5'h00) begin
      bad++; $display("FAIL right_scores got=%h/%h exp=01/00", p1(), p2());
    end
    run_miss(1'b0, 1'b1, 12, lows, first);
    total++;
    if (lows !== 8 || p1() !== 5'h02) begin
      bad++; $display("FAIL right_retrigger lows=%0d p1=%h exp=8/02", lows, p1());
    end
  endtask

  task automatic test_attract();
    int lows, first, sum;
    do_srst();
    sif.ATTRACT = 1'b1;
    sum = 0;
    for (int i = 0; i < 3; i++) begin
      run_miss(1'b1, 1'b0, 12, lows, first);
      sum += lows;
    end
    total++;
    if (sum !== 24) begin bad++; $display("FAIL attract_pulses got=%0d exp=24", sum); end
    total++;
    if (p1() !== 5'h00 || p2() !== 5'h00) begin
      bad++; $display("FAIL attract_scores got=%h/%h exp=00/00", p1(), p2());
    end
    sif.ATTRACT = 1'b0;
  endtask

  task automatic test_bcd_wrap();
    int lows, first;
    logic [4:0] exp_s;
    do_srst();
    sif.SCORE_15 = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      run_miss(1'b0, 1'b1, 12, lows, first);
      exp_s = (i < 10) ? {1'b0, 4'(i)} : 5'h10;
      total++;
      if (p1() !== exp_s) begin bad++; $display("FAIL bcd_wrap_%0d got=%h exp=%h", i, p1(), exp_s); end
    end
  endtask

  task automatic test_game11();
    int lows, first;
    do_srst();
    sif.SCORE_15 = 1'b0;
    for (int i = 0; i < 10; i++) run_miss(1'b1, 1'b0, 12, lows, first);
    sif.HIT_LEFT = 1'b1;
    tick();
    total++;
    if (p2() !== 5'h11 || sif.STOP_G !== 1'b0) begin
      bad++; $display("FAIL g11_first_cycle p2=%h stop=%b exp=11/0", p2(), sif.STOP_G);
    end
    tick();
    total++;
    if (sif.STOP_G !== 1'b1) begin bad++; $display("FAIL g11_stop_rise got=%b exp=1", sif.STOP_G); end
    repeat (10) tick();
    sif.HIT_LEFT = 1'b0;
    tick();
    tick();
    run_miss(1'b1, 1'b0, 12, lows, first);
    total++;
    if (lows !== 0 || p2() !== 5'h11) begin
      bad++; $display("FAIL g11_after_stop lows=%0d p2=%h exp=0/11", lows, p2());
    end
    do_srst();
    total++;
    if (sif.STOP_G !== 1'b0 || p1() !== 5'h00 || p2() !== 5'h00) begin
      bad++; $display("FAIL g11_srst stop=%b p1=%h p2=%h exp=0/00/00", sif.STOP_G, p1(), p2());
    end
  endtask

  task automatic test_game15();
    int lows, first;
    do_srst();
    sif.SCORE_15 = 1'b1;
    for (int i = 0; i < 11; i++) run_miss(1'b0, 1'b1, 12, lows, first);
    total++;
    if (sif.STOP_G !== 1'b0 || p1() !== 5'h11) begin
      bad++; $display("FAIL g15_at11 stop=%b p1=%h exp=0/11", sif.STOP_G, p1());
    end
    for (int i = 0; i < 4; i++) run_miss(1'b0, 1'b1, 12, lows, first);
    total++;
    if (sif.STOP_G !== 1'b1 || p1() !== 5'h15) begin
      bad++; $display("FAIL g15_at15 stop=%b p1=%h exp=1/15", sif.STOP_G, p1());
    end
    run_miss(1'b0, 1'b1, 12, lows, first);
    total++;
    if (lows !== 0 || p1() !== 5'h15) begin
      bad++; $display("FAIL g15_saturate lows=%0d p1=%h exp=0/15", lows, p1());
    end
  endtask

  task automatic test_target_change();
    int lows, first;
    do_srst();
    sif.SCORE_15 = 1'b1;
    for (int i = 0; i < 12; i++) run_miss(1'b0, 1'b1, 12, lows, first);
    total++;
    if (sif.STOP_G !== 1'b0 || p1() !== 5'h12) begin
      bad++; $display("FAIL tchg_before stop=%b p1=%h exp=0/12", sif.STOP_G, p1());
    end
    sif.SCORE_15 = 1'b0;
    tick();
    total++;
    if (sif.STOP_G !== 1'b1) begin bad++; $display("FAIL tchg_stop got=%b exp=1", sif.STOP_G); end
  endtask

  task automatic test_simultaneous();
    int lows, first;
    do_srst();
    run_miss(1'b1, 1'b1, 12, lows, first);
    total++;
    if (lows !== 8 || p2() !== 5'h01 || p1() !== 5'h00) begin
      bad++; $display("FAIL simul lows=%0d p1=%h p2=%h exp=8/00/01", lows, p1(), p2());
    end
  endtask

  task automatic test_srst_mid();
    sif.HIT_LEFT = 1'b1;
    repeat (3) tick();
    total++;
    if (sif.MISS_N !== 1'b0 || p2() !== 5'h02) begin
      bad++; $display("FAIL srst_mid_pre miss_n=%b p2=%h exp=0/02", sif.MISS_N, p2());
    end
    sif.SRST = 1'b1;
    tick();
    total++;
    if (sif.MISS_N !== 1'b1 || p1() !== 5'h00 || p2() !== 5'h00) begin
      bad++; $display("FAIL srst_mid miss_n=%b p1=%h p2=%h exp=1/00/00", sif.MISS_N, p1(), p2());
    end
    sif.SRST = 1'b0;
    sif.HIT_LEFT = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_fpga_reset_mid();
    sif.HIT_RIGHT = 1'b1;
    repeat (2) tick();
    total++;
    if (sif.MISS_N !== 1'b0) begin bad++; $display("FAIL frst_mid_pre got=%b exp=0", sif.MISS_N); end
    #1 FPGA_RESET = 1'b1;
    #1;
    total++;
    if (sif.MISS_N !== 1'b1 || p1() !== 5'h00) begin
      bad++; $display("FAIL frst_mid miss_n=%b p1=%h exp=1/00", sif.MISS_N, p1());
    end
    sif.HIT_RIGHT = 1'b0;
    tick();
    FPGA_RESET = 1'b0;
    tick();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_right_miss();
    test_attract();
    test_bcd_wrap();
    test_game11();
    test_game15();
    test_target_change();
    test_simultaneous();
    test_srst_mid();
    test_fpga_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
